display_scan_mux: RTL and testbench

DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

---
 rtl/display_scan_mux.sv | 141 ++++++++++++++
 tb/tb_display_scan_mux.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_mux.sv
// -----------------------------------------------------------------------------
// display_scan_mux
//   Time-multiplexed scan driver for an N_DIGITS x 4-bit display.
//
//   A prescaler divides clk by DIV. Each prescaler tick advances the digit
//   index, which wraps modulo N_DIGITS. Load requests are held pending and
//   committed to the display snapshot only on the frame-wrap tick, so every
//   frame shows a single consistent value. Optional leading-zero blanking and
//   per-digit enables darken individual digit strobes.
//
// Ports
//   clk        : system clock, all state on its rising edge
//   reset_n    : asynchronous active-low reset
//   HEX_in     : packed digits, digit i = HEX_in[4i+3:4i]
//   load       : request to capture HEX_in at the next frame wrap
//   digit_en   : per-digit enable, 0 forces that digit dark
//   blank_lz   : leading-zero blanking enable (digit 0 is never blanked)
//   BCD_4      : registered nibble of the digit currently driven
//   anodes     : registered one-hot-low digit strobe, all ones = dark
//   digit_sel  : registered index of the digit currently driven
//   frame_done : one-cycle pulse in the cycle after the wrap tick
// -----------------------------------------------------------------------------
module display_scan_mux #(
    parameter int  N_DIGITS = 8,
    parameter int  DIV      = 100000,
    localparam int IW       = $clog2(N_DIGITS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [4*N_DIGITS-1:0] HEX_in,
    input  logic                  load,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic                  blank_lz,
    output logic [3:0]            BCD_4,
    output logic [N_DIGITS-1:0]   anodes,
    output logic [IW-1:0]         digit_sel,
    output logic                  frame_done
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0]         r_presc;
    logic [IW-1:0]         r_idx;
    logic                  r_pending;
    logic [4*N_DIGITS-1:0] r_snap;
    logic [3:0]            r_bcd;
    logic [N_DIGITS-1:0]   r_anodes;
    logic [IW-1:0]         r_sel;
    logic                  r_frame_done;

    logic                  w_tick;
    logic                  w_wrap;
    logic [N_DIGITS-1:0]   w_lz;
    logic [3:0]            w_bcd_nxt;
    logic [N_DIGITS-1:0]   w_anodes_nxt;

    assign w_tick = (r_presc == PW'(DIV - 1));
    assign w_wrap = w_tick && (r_idx == IW'(N_DIGITS - 1));

    // Prescaler: counts 0..DIV-1; with DIV=1 it stays at 0 and ticks every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Digit index, explicit wrap so non-power-of-2 digit counts work.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx <= '0;
        end else if (w_tick) begin
            if (r_idx == IW'(N_DIGITS - 1)) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + IW'(1);
            end
        end
    end

    // Load handling: a load seen in the wrap cycle itself commits immediately,
    // otherwise it waits as pending. Snapshot only ever changes at the wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= 1'b0;
            r_snap    <= '0;
        end else if (w_wrap && (r_pending || load)) begin
            r_pending <= 1'b0;
            r_snap    <= HEX_in;
        end else if (load) begin
            r_pending <= 1'b1;
        end
    end

    // Leading-zero mask: digit i is blank when it and every higher digit are zero.
    always_comb begin
        w_lz = '0;
        w_lz[N_DIGITS-1] = blank_lz && (r_snap[4*(N_DIGITS-1) +: 4] == 4'h0);
        for (int unsigned k = 2; k < N_DIGITS; k++) begin
            w_lz[N_DIGITS-k] = w_lz[N_DIGITS-k+1] && (r_snap[4*(N_DIGITS-k) +: 4] == 4'h0);
        end
        w_lz[0] = 1'b0;
    end

    // Output decode for the current index; registered below for latency 1.
    always_comb begin
        w_bcd_nxt    = '0;
        w_anodes_nxt = '1;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_bcd_nxt = r_snap[4*i +: 4];
                if (digit_en[i] && !w_lz[i]) begin
                    w_anodes_nxt[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bcd        <= '0;
            r_anodes     <= '1;
            r_sel        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_bcd        <= w_bcd_nxt;
            r_anodes     <= w_anodes_nxt;
            r_sel        <= r_idx;
            r_frame_done <= w_wrap;
        end
    end

    assign BCD_4      = r_bcd;
    assign anodes     = r_anodes;
    assign digit_sel  = r_sel;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scan_mux.sv
module tb_display_scan_mux;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 8-digit, DIV=4 instance
    logic        rst8_n;
    logic [31:0] hex8;
    logic        load8;
    logic [7:0]  en8;
    logic        blz8;
    logic [3:0]  bcd8;
    logic [7:0]  an8;
    logic [2:0]  sel8;
    logic        fd8;

    // 6-digit, DIV=1 instance
    logic        rst6_n;
    logic [23:0] hex6;
    logic        load6;
    logic [5:0]  en6;
    logic        blz6;
    logic [3:0]  bcd6;
    logic [5:0]  an6;
    logic [2:0]  sel6;
    logic        fd6;

    int n_checks = 0;
    int n_pass   = 0;
    int fd_count = 0;

    display_scan_mux #(.N_DIGITS(8), .DIV(4)) u_dut8 (
        .clk(clk), .reset_n(rst8_n), .HEX_in(hex8), .load(load8),
        .digit_en(en8), .blank_lz(blz8), .BCD_4(bcd8), .anodes(an8),
        .digit_sel(sel8), .frame_done(fd8)
    );

    display_scan_mux #(.N_DIGITS(6), .DIV(1)) u_dut6 (
        .clk(clk), .reset_n(rst6_n), .HEX_in(hex6), .load(load6),
        .digit_en(en6), .blank_lz(blz6), .BCD_4(bcd6), .anodes(an6),
        .digit_sel(sel6), .frame_done(fd6)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst8_n = 1'b0; hex8 = '0; load8 = 1'b0; en8 = 8'hFF; blz8 = 1'b0;
        rst6_n = 1'b0; hex6 = '0; load6 = 1'b0; en6 = 6'h3F; blz6 = 1'b0;

        // Reset values
        step(2);
        check("rst bcd",  32'(bcd8), 32'h0);
        check("rst an",   32'(an8),  32'hFF);
        check("rst sel",  32'(sel8), 32'h0);
        check("rst fd",   32'(fd8),  32'h0);

        // Release with a single load of 1234_5678 (edge e1 follows)
        rst8_n = 1'b1; load8 = 1'b1; hex8 = 32'h1234_5678;
        step(1);                                  // e1
        load8 = 1'b0;
        check("e1 sel",   32'(sel8), 32'h0);
        check("e1 an",    32'(an8),  32'hFE);
        check("e1 bcd",   32'(bcd8), 32'h0);
        step(3);                                  // e4: first tick just happened
        check("e4 sel",   32'(sel8), 32'h0);
        step(1);                                  // e5
        check("e5 sel",   32'(sel8), 32'h1);
        check("e5 an",    32'(an8),  32'hFD);
        check("e5 bcd",   32'(bcd8), 32'h0);
        check("e5 fd",    32'(fd8),  32'h0);
        step(27);                                 // e32: wrap tick
        check("e32 fd",   32'(fd8),  32'h1);
        check("e32 sel",  32'(sel8), 32'h7);
        check("e32 bcd",  32'(bcd8), 32'h0);
        step(1);                                  // e33: new frame
        check("e33 fd",   32'(fd8),  32'h0);
        check("e33 sel",  32'(sel8), 32'h0);
        check("e33 bcd",  32'(bcd8), 32'h8);
        check("e33 an",   32'(an8),  32'hFE);
        for (int k = 1; k < 8; k++) begin
            step(3);
            check($sformatf("walk hold k=%0d", k), 32'(sel8), 32'(k - 1));
            step(1);
            check($sformatf("walk sel k=%0d", k), 32'(sel8), 32'(k));
            check($sformatf("walk bcd k=%0d", k), 32'(bcd8), 32'(8 - k));
            check($sformatf("walk an k=%0d", k),  32'(an8),  32'(8'hFF & ~(8'h1 << k)));
        end                                       // ends at e61

        // Mid-frame load at index 3
        step(16);                                 // e77
        check("mid sel3", 32'(sel8), 32'h3);
        check("mid bcd3", 32'(bcd8), 32'h5);
        hex8 = 32'hAAAA_AAAA; load8 = 1'b1;
        step(1);                                  // e78
        load8 = 1'b0;
        check("mid hold", 32'(bcd8), 32'h5);
        step(3);                                  // e81
        check("mid sel4", 32'(sel8), 32'h4);
        check("mid bcd4", 32'(bcd8), 32'h4);
        step(15);                                 // e96
        check("mid e96 sel", 32'(sel8), 32'h7);
        check("mid e96 bcd", 32'(bcd8), 32'h1);
        check("mid e96 fd",  32'(fd8),  32'h1);
        step(1);                                  // e97
        check("new sel0", 32'(sel8), 32'h0);
        check("new bcd0", 32'(bcd8), 32'hA);
        check("new an0",  32'(an8),  32'hFE);
        step(4);                                  // e101
        check("new bcd1", 32'(bcd8), 32'hA);
        check("new an1",  32'(an8),  32'hFD);

        // digit_en acts on the next update, without waiting for a tick
        en8 = 8'hFD;
        step(1);                                  // e102
        check("en imm off", 32'(an8), 32'hFF);
        en8 = 8'hFB;
        step(1);                                  // e103
        check("en imm on",  32'(an8), 32'hFD);
        step(2);                                  // e105: digit 2 slot
        check("en2 sel",  32'(sel8), 32'h2);
        check("en2 an",   32'(an8),  32'hFF);
        check("en2 bcd",  32'(bcd8), 32'hA);
        step(4);                                  // e109
        check("en3 an",   32'(an8),  32'hF7);
        en8 = 8'hFF;

        // Leading-zero blanking with snapshot 0000_0050
        hex8 = 32'h0000_0050; load8 = 1'b1; blz8 = 1'b1;
        step(1);                                  // e110
        load8 = 1'b0;
        step(19);                                 // e129
        check("lz d0 sel", 32'(sel8), 32'h0);
        check("lz d0 bcd", 32'(bcd8), 32'h0);
        check("lz d0 an",  32'(an8),  32'hFE);
        step(4);                                  // e133
        check("lz d1 bcd", 32'(bcd8), 32'h5);
        check("lz d1 an",  32'(an8),  32'hFD);
        step(4);                                  // e137
        check("lz d2 an",  32'(an8),  32'hFF);
        check("lz d2 bcd", 32'(bcd8), 32'h0);
        blz8 = 1'b0;
        step(1);                                  // e138
        check("lz off d2", 32'(an8),  32'hFB);
        blz8 = 1'b1; hex8 = 32'h0; load8 = 1'b1;
        step(1);                                  // e139
        load8 = 1'b0;
        check("lz on d2",  32'(an8),  32'hFF);
        step(22);                                 // e161: snapshot now 0
        check("z d0 an",   32'(an8),  32'hFE);
        step(4);                                  // e165
        check("z d1 an",   32'(an8),  32'hFF);

        // Pending load discarded by a mid-frame reset
        hex8 = 32'h1234_5678; load8 = 1'b1; blz8 = 1'b0;
        step(1);                                  // e166
        load8 = 1'b0;
        step(15);                                 // e181
        check("pre rst sel", 32'(sel8), 32'h5);
        check("pre rst an",  32'(an8),  32'hDF);
        #2;
        rst8_n = 1'b0;
        #1;
        check("async sel", 32'(sel8), 32'h0);
        check("async an",  32'(an8),  32'hFF);
        check("async bcd", 32'(bcd8), 32'h0);
        check("async fd",  32'(fd8),  32'h0);
        step(2);
        rst8_n = 1'b1;
        step(1);                                  // R1
        check("R1 an",   32'(an8),  32'hFE);
        step(3);                                  // R4
        check("R4 sel",  32'(sel8), 32'h0);
        step(1);                                  // R5
        check("R5 sel",  32'(sel8), 32'h1);
        step(27);                                 // R32
        check("R32 fd",  32'(fd8),  32'h1);
        step(1);                                  // R33
        check("R33 sel", 32'(sel8), 32'h0);
        check("R33 bcd", 32'(bcd8), 32'h0);
        step(4);                                  // R37
        check("R37 bcd", 32'(bcd8), 32'h0);

        // N=6, DIV=1: index every cycle, wrap at 5
        rst6_n = 1'b1; load6 = 1'b1; hex6 = 24'h54_3210;
        for (int k = 0; k < 18; k++) begin
            step(1);                              // edge m = k+1
            load6 = 1'b0;
            if (fd6) fd_count++;
            check($sformatf("n6 sel m=%0d", k + 1), 32'(sel6), 32'(k % 6));
            check($sformatf("n6 fd m=%0d", k + 1),  32'(fd6),  ((k + 1) % 6 == 0) ? 32'h1 : 32'h0);
            check($sformatf("n6 bcd m=%0d", k + 1), 32'(bcd6), (k + 1 >= 7) ? 32'(k % 6) : 32'h0);
            check($sformatf("n6 an m=%0d", k + 1),  32'(an6),  32'(6'h3F & ~(6'h1 << (k % 6))));
        end
        check("n6 fd count", 32'(fd_count), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
